obc_shift_accumulator: RTL and testbench
========================================

# obc_shift_accumulator

Bit-serial shift-accumulate stage of the OBC 16-point DFT datapath. It sits directly downstream of the 16-input OBC partial-sum ROM bank. Per output bin it sequences bit-planes MSB-first, driving the bit index and MSB flag `m` to the upstream bit-slicer and ROM bank. It accumulates the 32-bit signed `romout` with a left shift each cycle, adds the OBC offset constant, and presents the finished coefficient on a valid/ready output.

## Interface
- `DATA_W`, 8: bits per input sample, equal to the number of bit-plane cycles per result.
- `ROM_W`, 32: width of the signed partial sum from the ROM bank.
- `OUT_W`, 40: result width, must be ≥ ROM_W+DATA_W. All arithmetic is modulo 2^OUT_W.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request one conversion. Sampled only in IDLE.
- `busy` out 1: high in RUN and DONE.
- `bit_idx` out $clog2(DATA_W): bit-plane selector to the upstream bit-slicer.
- `m` out 1: MSB-plane flag to the ROM bank. High only in the RUN cycle where bit_idx==DATA_W-1.
- `romout` in ROM_W: signed partial sum. Combinational response to the current bit_idx/m.
- `offset` in ROM_W: signed OBC offset constant for the current bin. Sampled on the final RUN cycle only.
- `y` out OUT_W: signed result.
- `y_valid` out 1: result available.
- `y_ready` in 1: consumer accepts y.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0, y_valid=0, m=0, bit_idx=DATA_W-1.
  - `start`=1 moves to RUN, clears acc and sets bit_idx=DATA_W-1.
- RUN:
  - Each cycle, acc <= (acc<<1) + sext(romout), and bit_idx decrements.
  - On the cycle with bit_idx==0: y <= (acc<<1) + sext(romout) + sext(offset), then go to DONE.
  - acc is OUT_W wide; sext means sign-extend to OUT_W.
- DONE:
  - y_valid=1 and y is held stable until y_valid && y_ready.
  - On that handshake, go to IDLE.
- `start` is ignored in RUN and DONE. This includes `start` coinciding with the handshake cycle; no queuing.
- Overflow beyond OUT_W wraps silently. No saturation.
- `romout` and `offset` are don't-care outside the sampling points above.
- Reset, including mid-RUN or mid-DONE, immediately sets:
  - state=IDLE, acc=0, y=0, y_valid=0, busy=0, m=0, bit_idx=DATA_W-1.
  - The partial result is discarded.

## Timing
- `start` is accepted at edge 0. RUN occupies cycles 1..DATA_W.
  - Cycle 1 presents bit_idx=DATA_W-1 with m=1.
  - Cycle DATA_W presents bit_idx=0.
- y_valid rises in cycle DATA_W+1, i.e. latency DATA_W+1 from the start edge.
- bit_idx and m are registered outputs; no combinational path from `start`.
- The upstream ROM path is combinational within the cycle (bit_idx → romout).
- Throughput with y_ready tied high: one result per DATA_W+2 cycles. DONE lasts one cycle, then IDLE accepts the next `start`.
- Backpressure: y, y_valid and busy hold indefinitely while y_ready=0.

## Test plan
- DATA_W=8, romout=1 every RUN cycle, offset=0 → y=255, y_valid in cycle 9, m high only in cycle 1.
- romout=1 only while m=1, else 0, offset=0 → y=128. romout=-1 all cycles → y=-255 (0xFFFFFFFF01 at OUT_W=40).
- romout=0, offset=-100 → y=-100. romout=0x7FFFFFFF every cycle, offset=0 → y=0x7FFFFFFF×255, no wrap at OUT_W=40.
- Hold y_ready=0 for 5 cycles in DONE while pulsing `start` → y stable, busy=1, no new RUN. Raise y_ready → IDLE next cycle, and a later `start` runs normally.
- Assert rst_n=0 during RUN cycle 4 → all outputs at reset values asynchronously. After release, `start` with romout=1 → y=255, unaffected by the aborted run.
- Back-to-back with y_ready=1 and `start` held high → results every 10 cycles, bit_idx sequence 7..0 each run.

Source files
------------

// File: rtl/obc_shift_accumulator_if.sv
// obc_shift_accumulator_if: start/bit-plane/ROM/result signals between the OBC shift-accumulator and its neighbours.
interface obc_shift_accumulator_if #(
    parameter int DATA_W = 8,
    parameter int ROM_W  = 32,
    parameter int OUT_W  = 40
);
    localparam int BW = $clog2(DATA_W);
    logic              start;
    logic              busy;
    logic [BW-1:0]     bit_idx;
    logic              m;
    logic [ROM_W-1:0]  romout;
    logic [ROM_W-1:0]  offset;
    logic [OUT_W-1:0]  y;
    logic              y_valid;
    logic              y_ready;
    modport slave (
        input  start, romout, offset, y_ready,
        output busy, bit_idx, m, y, y_valid
    );
    modport master (
        output start, romout, offset, y_ready,
        input  busy, bit_idx, m, y, y_valid
    );
endinterface

// File: rtl/obc_shift_accumulator.sv
// obc_shift_accumulator: MSB-first bit-plane sequencer and shift-accumulator producing one OBC DFT coefficient per start.
module obc_shift_accumulator #(
    parameter int DATA_W = 8,
    parameter int ROM_W  = 32,
    parameter int OUT_W  = 40
) (
    input logic clk,
    input logic rst_n,
    obc_shift_accumulator_if.slave bus
);
    localparam int BW = $clog2(DATA_W);
    localparam logic [BW-1:0] TOP = BW'(DATA_W - 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;
    logic [OUT_W-1:0] acc;
    logic [OUT_W-1:0] rom_ext;
    logic [OUT_W-1:0] off_ext;
    logic [OUT_W-1:0] acc_next;
    assign rom_ext  = {{(OUT_W - ROM_W){bus.romout[ROM_W-1]}}, bus.romout};
    assign off_ext  = {{(OUT_W - ROM_W){bus.offset[ROM_W-1]}}, bus.offset};
    assign acc_next = (acc << 1) + rom_ext;
    // bit_idx parks at the top plane whenever not running so IDLE always presents DATA_W-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            acc         <= '0;
            bus.y       <= '0;
            bus.y_valid <= 1'b0;
            bus.busy    <= 1'b0;
            bus.m       <= 1'b0;
            bus.bit_idx <= TOP;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    state       <= RUN;
                    acc         <= '0;
                    bus.bit_idx <= TOP;
                    bus.m       <= 1'b1;
                    bus.busy    <= 1'b1;
                end
                RUN: begin
                    acc   <= acc_next;
                    bus.m <= 1'b0;
                    if (bus.bit_idx == '0) begin
                        bus.y       <= acc_next + off_ext;
                        bus.y_valid <= 1'b1;
                        bus.bit_idx <= TOP;
                        state       <= DONE;
                    end else begin
                        bus.bit_idx <= bus.bit_idx - 1'b1;
                    end
                end
                DONE: if (bus.y_ready) begin
                    bus.y_valid <= 1'b0;
                    bus.busy    <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_obc_shift_accumulator.sv
// tb_obc_shift_accumulator: table-driven conversions plus backpressure, mid-run reset and back-to-back sequences.
module tb_obc_shift_accumulator;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    obc_shift_accumulator_if #(.DATA_W(8), .ROM_W(32), .OUT_W(40)) bus();
    obc_shift_accumulator #(.DATA_W(8), .ROM_W(32), .OUT_W(40)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    int passed = 0;
    int total = 0;
    logic [31:0] rom_val = '0;
    int mode = 0;
    // mode 0: constant every plane, 1: constant only on the MSB plane, 2: romout equals bit_idx
    always_comb
        bus.romout = (mode == 2) ? {29'b0, bus.bit_idx} : (mode == 1 && !bus.m) ? 32'd0 : rom_val;
    typedef struct {
        string       name;
        logic [31:0] rom;
        int          md;
        logic [31:0] off;
        logic [39:0] exp;
    } vec_t;
    vec_t vecs[8];
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask
    task automatic run_conv(input string name, input logic [31:0] r, input int md,
                            input logic [31:0] o, input logic [39:0] e);
        bit ok = 1'b1;
        rom_val = r;
        mode = md;
        bus.offset = o;
        bus.y_ready = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (bus.bit_idx !== 3'(8 - c) || bus.m !== (c == 1) || bus.busy !== 1'b1 || bus.y_valid !== 1'b0)
                ok = 1'b0;
            @(negedge clk);
        end
        check({name, "_seq"}, 64'(ok), 64'd1);
        check({name, "_valid9"}, 64'(bus.y_valid), 64'd1);
        check({name, "_y"}, 64'(bus.y), 64'(e));
        @(negedge clk);
        check({name, "_idle"}, {62'd0, bus.busy, bus.y_valid}, 64'd0);
    endtask
    initial begin
        vecs[0] = '{"ones",   32'd1,          0, 32'd0,             40'd255};
        vecs[1] = '{"msb",    32'd1,          1, 32'd0,             40'd128};
        vecs[2] = '{"neg1",   32'hFFFFFFFF,   0, 32'd0,             40'hFFFFFFFF01};
        vecs[3] = '{"offset", 32'd0,          0, 32'hFFFFFF9C,      40'hFFFFFFFF9C};
        vecs[4] = '{"maxpos", 32'h7FFFFFFF,   0, 32'd0,             40'h7F7FFFFF01};
        vecs[5] = '{"three",  32'd3,          0, 32'd5,             40'd770};
        vecs[6] = '{"msbneg", 32'hFFFFFFFE,   1, 32'd7,             40'hFFFFFFFF07};
        vecs[7] = '{"ramp",   32'd0,          2, 32'd0,             40'd1538};
        bus.start = 1'b0;
        bus.y_ready = 1'b1;
        bus.offset = '0;
        #12;
        check("rst_outs", {bus.y, 19'd0, bus.busy, bus.y_valid, bus.m, bus.bit_idx}, {40'd0, 19'd0, 3'b000, 3'd7});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        foreach (vecs[i]) run_conv(vecs[i].name, vecs[i].rom, vecs[i].md, vecs[i].off, vecs[i].exp);
        // backpressure with start pulsing in DONE
        begin
            bit ok = 1'b1;
            rom_val = 32'd1; mode = 0; bus.offset = '0; bus.y_ready = 1'b0;
            bus.start = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus.start = 1'b0;
            repeat (8) @(negedge clk);
            for (int c = 0; c < 5; c++) begin
                bus.start = c[0];
                if (bus.y !== 40'd255 || bus.busy !== 1'b1 || bus.y_valid !== 1'b1 || bus.m !== 1'b0) ok = 1'b0;
                @(negedge clk);
            end
            check("bp_hold", 64'(ok), 64'd1);
            check("bp_y", 64'(bus.y), 64'd255);
            bus.start = 1'b0;
            bus.y_ready = 1'b1;
            @(negedge clk);
            check("bp_release", {61'd0, bus.busy, bus.y_valid, bus.m}, 64'd0);
            check("bp_idx", 64'(bus.bit_idx), 64'd7);
        end
        run_conv("after_bp", 32'd1, 0, 32'd0, 40'd255);
        // asynchronous reset during RUN cycle 4
        rom_val = 32'd5; mode = 0;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_idx", 64'(bus.bit_idx), 64'd4);
        #2 rst_n = 1'b0;
        #1 check("async_rst", {bus.y, 19'd0, bus.busy, bus.y_valid, bus.m, bus.bit_idx}, {40'd0, 19'd0, 3'b000, 3'd7});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_conv("post_rst", 32'd1, 0, 32'd0, 40'd255);
        // back-to-back with start held high
        begin
            bit ok = 1'b1;
            int nvalid = 0;
            logic [2:0] exp_idx = 3'd7;
            rom_val = 32'd1; mode = 0; bus.offset = '0; bus.y_ready = 1'b1;
            bus.start = 1'b1;
            for (int i = 1; i <= 38; i++) begin
                @(negedge clk);
                if (bus.y_valid) begin
                    if (i != 9 + 10 * nvalid || bus.y !== 40'd255) ok = 1'b0;
                    nvalid++;
                    exp_idx = 3'd7;
                end else if (bus.busy) begin
                    if (bus.bit_idx !== exp_idx || bus.m !== (exp_idx == 3'd7)) ok = 1'b0;
                    exp_idx = exp_idx - 3'd1;
                end
            end
            bus.start = 1'b0;
            check("b2b_timing", 64'(ok), 64'd1);
            check("b2b_count", 64'(nvalid), 64'd3);
            @(negedge clk);
            check("b2b_last", {23'd0, bus.y_valid, bus.y}, {23'd0, 1'b1, 40'd255});
            @(negedge clk);
            check("b2b_idle", {62'd0, bus.busy, bus.y_valid}, 64'd0);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
